// File: rtl/bp_host_io_arbiter_pkg.sv
// Shared helpers for the host I/O arbiter slice.
// Messages stay opaque vectors; only width math lives here.
package bp_host_io_arbiter_pkg;

   // Index width that never collapses to zero bits.
   function automatic int unsigned safe_clog2(
      input int unsigned n
   );
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_host_io_arbiter_rr.sv
// Round-robin arbiter: picks the first valid requester
// searching from a pointer that moves past each winner.
// Ports: clk_i, reset_n_i, reqs_i (valids), yumi_i/yumi_id_i
// (accepted requester), grant_v_o/grant_id_o (current pick).
module bp_host_io_arbiter_rr
   import bp_host_io_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p = 4,
   localparam int unsigned TagW = safe_clog2(num_req_p)
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [num_req_p-1:0] reqs_i,
   input  logic                 yumi_i,
   input  logic [TagW-1:0]      yumi_id_i,
   output logic                 grant_v_o,
   output logic [TagW-1:0]      grant_id_o
);

   logic [TagW-1:0] r_ptr;
   int unsigned     w_idx;

   // Scan from the far end back toward the pointer so the
   // last hit written is the nearest one at or after it.
   always_comb begin
      grant_v_o  = 1'b0;
      grant_id_o = '0;
      w_idx      = 0;
      for (int k = num_req_p - 1; k >= 0; k--) begin
         w_idx = (int'(r_ptr) + k) % num_req_p;
         if (reqs_i[w_idx]) begin
            grant_v_o  = 1'b1;
            grant_id_o = TagW'(w_idx);
         end
      end
   end

   // Advance past whoever was actually accepted, which may
   // be a locked grant rather than the current pick.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_ptr <= '0;
      end else if (yumi_i) begin
         if (yumi_id_i == TagW'(num_req_p - 1))
            r_ptr <= '0;
         else
            r_ptr <= yumi_id_i + TagW'(1);
      end
   end

endmodule

// File: rtl/bp_host_io_arbiter_tagq.sv
// In-order tag queue holding the source id of each command
// in flight. Ports: v_i/data_i push, yumi_i pop, data_o head,
// empty_o/full_o status.
module bp_host_io_arbiter_tagq
   import bp_host_io_arbiter_pkg::*;
#(
   parameter int unsigned width_p = 2,
   parameter int unsigned els_p   = 32,
   localparam int unsigned PtrW = safe_clog2(els_p),
   localparam int unsigned CntW = $clog2(els_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   input  logic               yumi_i,
   output logic [width_p-1:0] data_o,
   output logic               empty_o,
   output logic               full_o
);

   logic [width_p-1:0] r_mem [els_p];
   logic [PtrW-1:0]    r_wptr;
   logic [PtrW-1:0]    r_rptr;
   logic [CntW-1:0]    r_cnt;

   function automatic logic [PtrW-1:0] bump(
      input logic [PtrW-1:0] p
   );
      return (p == PtrW'(els_p - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (v_i)
         r_mem[r_wptr] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (v_i)
            r_wptr <= bump(r_wptr);
         if (yumi_i)
            r_rptr <= bump(r_rptr);
         if (v_i && !yumi_i)
            r_cnt <= r_cnt + CntW'(1);
         else if (!v_i && yumi_i)
            r_cnt <= r_cnt - CntW'(1);
      end
   end

   assign data_o  = r_mem[r_rptr];
   assign empty_o = (r_cnt == '0);
   assign full_o  = (r_cnt == CntW'(els_p));

endmodule

// File: rtl/bp_host_io_arbiter.sv
// Shares one host command/response channel among requesters.
// Ports: req_* per-requester channels, host_* shared channel,
// drain_i/idle_o quiesce, outstanding_o count, err_o stray.
module bp_host_io_arbiter
   import bp_host_io_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p         = 4,
   parameter int unsigned msg_width_p       = 128,
   parameter int unsigned max_outstanding_p = 32,
   localparam int unsigned TagW = safe_clog2(num_req_p),
   localparam int unsigned CntW =
      $clog2(max_outstanding_p + 1),
   localparam int unsigned ReqW = num_req_p * msg_width_p
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [ReqW-1:0]        req_cmd_i,
   input  logic [num_req_p-1:0]   req_cmd_v_i,
   output logic [num_req_p-1:0]   req_cmd_ready_and_o,
   output logic [ReqW-1:0]        req_resp_o,
   output logic [num_req_p-1:0]   req_resp_v_o,
   input  logic [num_req_p-1:0]   req_resp_yumi_i,
   output logic [msg_width_p-1:0] host_cmd_o,
   output logic                   host_cmd_v_o,
   input  logic                   host_cmd_ready_and_i,
   input  logic [msg_width_p-1:0] host_resp_i,
   input  logic                   host_resp_v_i,
   output logic                   host_resp_yumi_o,
   input  logic                   drain_i,
   output logic                   idle_o,
   output logic [CntW-1:0]        outstanding_o,
   output logic                   err_o
);

   typedef enum logic [1:0] {
      e_run,
      e_drain,
      e_idle
   } state_e;

   state_e          r_state;
   logic            r_idle;
   logic            r_err;
   logic            r_lock;
   logic [TagW-1:0] r_lock_id;
   logic [CntW-1:0] r_cnt;

   logic            w_arb_v;
   logic [TagW-1:0] w_arb_id;
   logic            w_gnt_v;
   logic [TagW-1:0] w_gnt_id;
   logic [TagW-1:0] w_head;
   logic            w_empty;
   logic            w_full;
   logic            w_cmd_v;
   logic            w_push;
   logic            w_resp_v;
   logic            w_pop;
   logic            w_stray;

   bp_host_io_arbiter_rr #(
      .num_req_p (num_req_p)
   ) u_rr (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .reqs_i     (req_cmd_v_i),
      .yumi_i     (w_push),
      .yumi_id_i  (w_gnt_id),
      .grant_v_o  (w_arb_v),
      .grant_id_o (w_arb_id)
   );

   bp_host_io_arbiter_tagq #(
      .width_p (TagW),
      .els_p   (max_outstanding_p)
   ) u_tagq (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (w_push),
      .data_i    (w_gnt_id),
      .yumi_i    (w_pop),
      .data_o    (w_head),
      .empty_o   (w_empty),
      .full_o    (w_full)
   );

   // A presented-but-unaccepted command pins the grant.
   assign w_gnt_id = r_lock ? r_lock_id : w_arb_id;
   assign w_gnt_v  = r_lock ? req_cmd_v_i[r_lock_id]
                            : w_arb_v;

   assign w_resp_v = reset_n_i & host_resp_v_i & ~w_empty;
   assign w_pop    = w_resp_v & req_resp_yumi_i[w_head];
   assign w_stray  = reset_n_i & host_resp_v_i & w_empty;

   // A same-cycle pop frees a slot for a command while full.
   assign w_cmd_v = reset_n_i & w_gnt_v
                  & (~w_full | w_pop)
                  & (r_state == e_run);
   assign w_push  = w_cmd_v & host_cmd_ready_and_i;

   always_comb begin
      req_cmd_ready_and_o = '0;
      req_resp_v_o        = '0;
      if (w_push)
         req_cmd_ready_and_o[w_gnt_id] = 1'b1;
      if (w_resp_v)
         req_resp_v_o[w_head] = 1'b1;
   end

   assign host_cmd_o =
      req_cmd_i[w_gnt_id*msg_width_p +: msg_width_p];
   assign host_cmd_v_o     = w_cmd_v;
   assign req_resp_o       = {num_req_p{host_resp_i}};
   assign host_resp_yumi_o = w_pop | w_stray;
   assign idle_o           = r_idle;
   assign err_o            = r_err;
   assign outstanding_o    = r_cnt;

   // Lock only survives while the command stays presented,
   // so leaving e_run or a dropped valid releases it.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_lock    <= 1'b0;
         r_lock_id <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_lock    <= w_cmd_v & ~host_cmd_ready_and_i;
         r_lock_id <= w_gnt_id;
         r_err     <= r_err | w_stray;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + CntW'(1);
         else if (!w_push && w_pop)
            r_cnt <= r_cnt - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= e_run;
         r_idle  <= 1'b0;
      end else begin
         unique case (r_state)
            e_run: begin
               r_idle <= 1'b0;
               if (drain_i)
                  r_state <= e_drain;
            end
            e_drain: begin
               if (!drain_i) begin
                  r_state <= e_run;
                  r_idle  <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state <= e_idle;
                  r_idle  <= 1'b1;
               end
            end
            e_idle: begin
               if (!drain_i) begin
                  r_state <= e_run;
                  r_idle  <= 1'b0;
               end
            end
            default: begin
               r_state <= e_run;
               r_idle  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_host_io_arbiter.sv
// Directed bench for bp_host_io_arbiter: arbitration, lock,
// full, backpressure, drain and stray-response scenarios.
module tb_bp_host_io_arbiter;

   localparam int N  = 4;
   localparam int W  = 128;
   localparam int MO = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*W-1:0] req_cmd;
   logic [N-1:0]   req_v = '0;
   logic [N-1:0]   req_rdy;
   logic [N*W-1:0] req_resp;
   logic [N-1:0]   req_resp_v;
   logic [N-1:0]   yumi = '0;
   logic [W-1:0]   host_cmd;
   logic           host_cmd_v;
   logic           host_rdy = 1'b0;
   logic [W-1:0]   host_resp = '0;
   logic           host_resp_v = 1'b0;
   logic           host_yumi;
   logic           drain = 1'b0;
   logic           idle;
   logic [5:0]     outst;
   logic           err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bp_host_io_arbiter #(
      .num_req_p         (N),
      .msg_width_p       (W),
      .max_outstanding_p (MO)
   ) dut (
      .clk_i                (clk),
      .reset_n_i            (rst_n),
      .req_cmd_i            (req_cmd),
      .req_cmd_v_i          (req_v),
      .req_cmd_ready_and_o  (req_rdy),
      .req_resp_o           (req_resp),
      .req_resp_v_o         (req_resp_v),
      .req_resp_yumi_i      (yumi),
      .host_cmd_o           (host_cmd),
      .host_cmd_v_o         (host_cmd_v),
      .host_cmd_ready_and_i (host_rdy),
      .host_resp_i          (host_resp),
      .host_resp_v_i        (host_resp_v),
      .host_resp_yumi_o     (host_yumi),
      .drain_i              (drain),
      .idle_o               (idle),
      .outstanding_o        (outst),
      .err_o                (err)
   );

   function automatic logic [W-1:0] cmd_of(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'(i * 3 + 7),
              32'hFACE_0000 + 32'(i), 32'(i + 1)};
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      return N'(1 << i);
   endfunction

   initial begin
      for (int i = 0; i < N; i++)
         req_cmd[i*W +: W] = cmd_of(i);
   end

   task automatic test_reset();
      @(negedge clk);
      req_v = '1; host_rdy = 1; host_resp_v = 1; yumi = '1;
      #1;
      n_cmp++; if (req_rdy !== 4'b0) begin n_bad++;
         $display("FAIL rst_ready got=%b exp=0000", req_rdy); end
      n_cmp++; if (host_cmd_v !== 1'b0) begin n_bad++;
         $display("FAIL rst_cmd_v got=%b exp=0", host_cmd_v); end
      n_cmp++; if (host_yumi !== 1'b0) begin n_bad++;
         $display("FAIL rst_yumi got=%b exp=0", host_yumi); end
      n_cmp++; if (req_resp_v !== 4'b0) begin n_bad++;
         $display("FAIL rst_resp_v got=%b exp=0000",
                  req_resp_v); end
      @(negedge clk);
      rst_n = 1; req_v = '0; host_rdy = 0;
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL rst_outst got=%0d exp=0", outst); end
      n_cmp++; if (err !== 1'b0) begin n_bad++;
         $display("FAIL rst_err got=%b exp=0", err); end
      n_cmp++; if (idle !== 1'b0) begin n_bad++;
         $display("FAIL rst_idle got=%b exp=0", idle); end
   endtask

   task automatic test_round_robin();
      int exp_g [4] = '{0, 2, 0, 2};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_v = 4'b0101; host_rdy = 1;
         #1;
         n_cmp++; if (host_cmd !== cmd_of(exp_g[i])) begin
            n_bad++;
            $display("FAIL rr_cmd%0d got=%h exp=%h", i,
                     host_cmd, cmd_of(exp_g[i])); end
         n_cmp++; if (req_rdy !== oh(exp_g[i])) begin n_bad++;
            $display("FAIL rr_ready%0d got=%b exp=%b", i,
                     req_rdy, oh(exp_g[i])); end
      end
      @(negedge clk);
      req_v = '0; host_rdy = 0;
      #1;
      n_cmp++; if (outst !== 6'd4) begin n_bad++;
         $display("FAIL rr_outst got=%0d exp=4", outst); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         host_resp_v = 1; host_resp = 128'hBEEF + 128'(i);
         yumi = oh(exp_g[i]);
         #1;
         n_cmp++; if (req_resp_v !== oh(exp_g[i])) begin
            n_bad++;
            $display("FAIL rr_resp_v%0d got=%b exp=%b", i,
                     req_resp_v, oh(exp_g[i])); end
         n_cmp++; if (host_yumi !== 1'b1) begin n_bad++;
            $display("FAIL rr_yumi%0d got=%b exp=1", i,
                     host_yumi); end
         n_cmp++;
         if (req_resp[exp_g[i]*W +: W] !== 128'hBEEF + 128'(i))
         begin n_bad++;
            $display("FAIL rr_resp_data%0d got=%h exp=%h", i,
                     req_resp[exp_g[i]*W +: W],
                     128'hBEEF + 128'(i)); end
      end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL rr_outst_end got=%0d exp=0", outst); end
   endtask

   task automatic test_grant_lock();
      @(negedge clk);
      req_v = 4'b0010; host_rdy = 0;
      #1;
      n_cmp++; if (host_cmd_v !== 1'b1) begin n_bad++;
         $display("FAIL lock_v got=%b exp=1", host_cmd_v); end
      for (int s = 1; s < 5; s++) begin
         @(negedge clk);
         if (s == 2) req_v = 4'b1010;
         #1;
         n_cmp++; if (host_cmd !== cmd_of(1)) begin n_bad++;
            $display("FAIL lock_hold%0d got=%h exp=%h", s,
                     host_cmd, cmd_of(1)); end
         n_cmp++; if (req_rdy !== 4'b0) begin n_bad++;
            $display("FAIL lock_rdy%0d got=%b exp=0000", s,
                     req_rdy); end
      end
      @(negedge clk);
      host_rdy = 1;
      #1;
      n_cmp++; if (req_rdy !== 4'b0010) begin n_bad++;
         $display("FAIL lock_hs1 got=%b exp=0010", req_rdy); end
      @(negedge clk);
      #1;
      n_cmp++; if (host_cmd !== cmd_of(3)) begin n_bad++;
         $display("FAIL lock_next got=%h exp=%h", host_cmd,
                  cmd_of(3)); end
      n_cmp++; if (req_rdy !== 4'b1000) begin n_bad++;
         $display("FAIL lock_hs3 got=%b exp=1000", req_rdy); end
      @(negedge clk);
      req_v = '0; host_rdy = 0;
      #1;
      n_cmp++; if (outst !== 6'd2) begin n_bad++;
         $display("FAIL lock_outst got=%0d exp=2", outst); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         host_resp_v = 1; yumi = (i == 0) ? 4'b0010 : 4'b1000;
         #1;
         n_cmp++; if (req_resp_v !== yumi) begin n_bad++;
            $display("FAIL lock_resp%0d got=%b exp=%b", i,
                     req_resp_v, yumi); end
      end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
   endtask

   task automatic test_full();
      @(negedge clk);
      req_v = 4'b0001; host_rdy = 1;
      repeat (MO) @(negedge clk);
      #1;
      n_cmp++; if (outst !== 6'd32) begin n_bad++;
         $display("FAIL full_outst got=%0d exp=32", outst); end
      n_cmp++; if (host_cmd_v !== 1'b0) begin n_bad++;
         $display("FAIL full_cmd_v got=%b exp=0", host_cmd_v); end
      n_cmp++; if (req_rdy !== 4'b0) begin n_bad++;
         $display("FAIL full_rdy got=%b exp=0000", req_rdy); end
      @(negedge clk);
      host_resp_v = 1; yumi = 4'b0001;
      #1;
      n_cmp++; if (host_yumi !== 1'b1) begin n_bad++;
         $display("FAIL full_pop got=%b exp=1", host_yumi); end
      n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++;
         $display("FAIL full_swap_rdy got=%b exp=0001",
                  req_rdy); end
      @(negedge clk);
      host_resp_v = 0; yumi = '0; req_v = '0; host_rdy = 0;
      #1;
      n_cmp++; if (outst !== 6'd32) begin n_bad++;
         $display("FAIL full_swap_outst got=%0d exp=32",
                  outst); end
      for (int i = 0; i < MO; i++) begin
         @(negedge clk);
         host_resp_v = 1; yumi = 4'b0001;
         #1;
         n_cmp++; if (req_resp_v !== 4'b0001) begin n_bad++;
            $display("FAIL full_drain%0d got=%b exp=0001", i,
                     req_resp_v); end
      end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL full_end got=%0d exp=0", outst); end
   endtask

   task automatic test_yumi_hold();
      @(negedge clk);
      req_v = 4'b0010; host_rdy = 1;
      #1;
      n_cmp++; if (req_rdy !== 4'b0010) begin n_bad++;
         $display("FAIL hold_issue got=%b exp=0010", req_rdy); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_v = '0; host_rdy = 0; host_resp_v = 1; yumi = '0;
         #1;
         n_cmp++; if (req_resp_v !== 4'b0010) begin n_bad++;
            $display("FAIL hold_v%0d got=%b exp=0010", c,
                     req_resp_v); end
         n_cmp++; if (host_yumi !== 1'b0) begin n_bad++;
            $display("FAIL hold_yumi%0d got=%b exp=0", c,
                     host_yumi); end
         n_cmp++; if (outst !== 6'd1) begin n_bad++;
            $display("FAIL hold_outst%0d got=%0d exp=1", c,
                     outst); end
      end
      @(negedge clk);
      yumi = 4'b0010;
      #1;
      n_cmp++; if (host_yumi !== 1'b1) begin n_bad++;
         $display("FAIL hold_pop got=%b exp=1", host_yumi); end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL hold_end got=%0d exp=0", outst); end
   endtask

   task automatic test_drain();
      int exp_g [3] = '{2, 0, 1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_v = 4'b0111; host_rdy = 1;
         #1;
         n_cmp++; if (req_rdy !== oh(exp_g[i])) begin n_bad++;
            $display("FAIL drn_issue%0d got=%b exp=%b", i,
                     req_rdy, oh(exp_g[i])); end
      end
      @(negedge clk);
      req_v = '0; drain = 1;
      #1;
      n_cmp++; if (outst !== 6'd3) begin n_bad++;
         $display("FAIL drn_outst got=%0d exp=3", outst); end
      @(negedge clk);
      req_v = '1;
      #1;
      n_cmp++; if (host_cmd_v !== 1'b0) begin n_bad++;
         $display("FAIL drn_block got=%b exp=0", host_cmd_v); end
      n_cmp++; if (req_rdy !== 4'b0) begin n_bad++;
         $display("FAIL drn_rdy got=%b exp=0000", req_rdy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         host_resp_v = 1; yumi = oh(exp_g[i]);
         #1;
         n_cmp++; if (req_resp_v !== oh(exp_g[i])) begin
            n_bad++;
            $display("FAIL drn_resp%0d got=%b exp=%b", i,
                     req_resp_v, oh(exp_g[i])); end
         n_cmp++; if (idle !== 1'b0) begin n_bad++;
            $display("FAIL drn_idle%0d got=%b exp=0", i,
                     idle); end
      end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (idle !== 1'b0) begin n_bad++;
         $display("FAIL drn_idle_early got=%b exp=0", idle); end
      @(negedge clk);
      #1;
      n_cmp++; if (idle !== 1'b1) begin n_bad++;
         $display("FAIL drn_idle got=%b exp=1", idle); end
      @(negedge clk);
      drain = 0; host_rdy = 0;
      #1;
      n_cmp++; if (host_cmd_v !== 1'b0) begin n_bad++;
         $display("FAIL drn_exit_v got=%b exp=0", host_cmd_v); end
      @(negedge clk);
      host_rdy = 1;
      #1;
      n_cmp++; if (idle !== 1'b0) begin n_bad++;
         $display("FAIL drn_run_idle got=%b exp=0", idle); end
      n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++;
         $display("FAIL drn_resume got=%b exp=0100", req_rdy); end
      @(negedge clk);
      req_v = '0; host_rdy = 0; host_resp_v = 1; yumi = 4'b0100;
      #1;
      n_cmp++; if (req_resp_v !== 4'b0100) begin n_bad++;
         $display("FAIL drn_last got=%b exp=0100",
                  req_resp_v); end
      @(negedge clk);
      host_resp_v = 0; yumi = '0;
      #1;
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL drn_end got=%0d exp=0", outst); end
   endtask

   task automatic test_stray();
      @(negedge clk);
      host_resp_v = 1; yumi = '0;
      #1;
      n_cmp++; if (host_yumi !== 1'b1) begin n_bad++;
         $display("FAIL stray_sink got=%b exp=1", host_yumi); end
      n_cmp++; if (req_resp_v !== 4'b0) begin n_bad++;
         $display("FAIL stray_v got=%b exp=0000", req_resp_v); end
      @(negedge clk);
      host_resp_v = 0;
      #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++;
         $display("FAIL stray_err got=%b exp=1", err); end
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++;
         $display("FAIL stray_sticky got=%b exp=1", err); end
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL stray_outst got=%0d exp=0", outst); end
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++;
         $display("FAIL stray_rst_err got=%b exp=0", err); end
      n_cmp++; if (outst !== 6'd0) begin n_bad++;
         $display("FAIL stray_rst_outst got=%0d exp=0",
                  outst); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_grant_lock();
      test_full();
      test_yumi_hold();
      test_drain();
      test_stray();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_host_io_arbiter.md
Name: bp_host_io_arbiter

Overview:
- Shares one host I/O command/response channel between num_req_p requesters (per-core I/O ports) ahead of the nonsynthesizable host.
- Commands are arbitrated round-robin, one per cycle max; the source id of each accepted command is recorded in an in-order tag queue.
- The host answers in order, so each response is steered back to the requester at the head of the tag queue.
- A drain/quiesce FSM lets the testbench stop new traffic and wait for all outstanding commands to retire.

Parameters:
- num_req_p, 4, number of requesters (>=1).
- msg_width_p, 128, width of one memory message (header plus data), passed through opaquely.
- max_outstanding_p, 32, tag queue depth, i.e. the maximum number of commands in flight to the host.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command
- req_cmd_v_i  in  num_req_p  command valid
- req_cmd_ready_and_o  out  num_req_p  command ready (valid/ready_and handshake)
- req_resp_o  out  num_req_p*msg_width_p  per-requester response; every slice carries the host response
- req_resp_v_o  out  num_req_p  response valid
- req_resp_yumi_i  in  num_req_p  response consumed
- host_cmd_o  out  msg_width_p  command to host
- host_cmd_v_o  out  1  command valid
- host_cmd_ready_and_i  in  1  host ready
- host_resp_i  in  msg_width_p  host response
- host_resp_v_i  in  1  response valid
- host_resp_yumi_o  out  1  response consumed
- drain_i  in  1  level request to quiesce
- idle_o  out  1  drained and no commands outstanding
- outstanding_o  out  clog2(max_outstanding_p+1)  in-flight count
- err_o  out  1  sticky error: response arrived with the tag queue empty

Behaviour:
- Reset (reset_n_i low at a posedge):
  - FSM to e_run; round-robin pointer to 0; tag queue emptied.
  - outstanding_o=0, err_o=0, idle_o=0.
  - All ready/valid/yumi outputs low during reset.
- Command path:
  - Grant is the first requester with req_cmd_v_i set, searching from the pointer.
  - host_cmd_v_o = grant_v & ~tag_full & (state==e_run); host_cmd_o = command of the granted requester.
  - req_cmd_ready_and_o[g] = host_cmd_ready_and_i & host_cmd_v_o, for the granted g only. Path is combinational, zero added latency.
  - Grant lock: once host_cmd_v_o rises, the grant holds until the handshake completes, even if a higher-priority requester raises valid.
  - On handshake: pointer <= g+1 (wraps num_req_p-1 -> 0), and g is pushed into the tag queue.
- Response path:
  - req_resp_v_o[head] = host_resp_v_i & ~tag_empty; all other bits 0.
  - host_resp_yumi_o = req_resp_yumi_i[head]; on yumi the tag queue pops.
  - A response is valid to its requester in the same cycle host_resp_v_i rises. It is held until yumi; the host must hold it stable.
- Stray response (host_resp_v_i & tag_empty): host_resp_yumi_o=1 that cycle (sink), err_o <= 1 (sticky until reset), $error in simulation.
- outstanding_o: +1 on command handshake, -1 on response yumi; simultaneous +1/-1 leaves it unchanged. Range 0..max_outstanding_p, never wraps.
- Full: at outstanding == max_outstanding_p, host_cmd_v_o=0 and all ready outputs are 0. Accepting a response and a command in the same cycle while full is allowed: the pop frees a slot combinationally.
- FSM:
  - e_run -> e_drain when drain_i=1. No new grants in e_drain; a handshake already completed is unaffected. Grant lock cannot strand a command: while drain_i is pending, host_cmd_v_o is permitted to drop before the handshake, since the host is valid-agnostic.
  - e_drain -> e_idle when outstanding_o==0; idle_o=1 only in e_idle.
  - e_drain/e_idle -> e_run when drain_i=0.
- Reset mid-operation discards all tags. Responses for pre-reset commands are treated as stray.

Decomposition:
- No new package types: messages are opaque vectors; the integrating top casts them to bp_bedrock_cce_mem_msg_s.
- FSM state enum (e_run, e_drain, e_idle) is local to the module.
- Sub-modules: a bsg_fifo_1r1w_small instance of width clog2(num_req_p) and depth max_outstanding_p as the tag queue, and a bsg_arb_round_robin instance for arbitration.
- Locking logic and the outstanding counter (bsg_counter_up_down) live in the top.

Test Plan:
- Requesters 0 and 2 both valid continuously, host always ready -> grants alternate 0,2,0,2. Tags recorded are 0,2,0,2 and responses route to req_resp_v_o = 0001, 0100, 0001, 0100.
- Host not ready for 5 cycles while requester 3 (higher priority after wrap) raises valid mid-stall -> host_cmd_o stays requester 1's message until handshake; requester 3 is granted next.
- Host accepts 32 commands with no responses -> outstanding_o=32, all ready outputs 0. One response and one command in the same cycle -> outstanding_o stays 32.
- Requester 1 holds req_resp_yumi_i low for 4 cycles -> host_resp_yumi_o low for those 4 cycles; pop occurs on cycle 5 and outstanding decrements by 1.
- drain_i=1 with 3 in flight -> no grants, idle_o=0; after 3 responses idle_o=1 the next cycle. drain_i=0 -> grants resume.
- host_resp_v_i asserted with nothing outstanding -> host_resp_yumi_o=1, err_o=1 and stays 1; reset_n_i low for one cycle -> err_o=0, outstanding_o=0.
